// File: rtl/tmc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tmc_spi_responder
// Description : SPI mode-0 register-file responder, oversampled on clk.
//               Frame = 8-bit command (bit 7 = read, low ADDR_W bits = address)
//               followed by DATA_W data bits, MSB first. A read returns the
//               addressed register on miso; a write commits the received data
//               into the register file at the end of the data phase.
//               A local load port (ld_*) also writes the register file; an SPI
//               commit to the same address in the same clk takes priority.
// Ports       : clk, rst             - system clock, async active-high reset
//               sclk, csn, mosi      - SPI master signals (asynchronous)
//               miso, miso_oe        - SPI data out and its output enable
//               ld_en/ld_addr/ld_data- local register load
//               wr_stb/wr_addr/wr_data - committed SPI write notification
//               frame_done/frame_err - end-of-frame status pulses
// Parameters  : DATA_W (>= 2), ADDR_W (2..7)
// Revision    : 1.0 - initial release
// ============================================================================
module tmc_spi_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              csn,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int c_NREG       = 2 ** ADDR_W;
    localparam int c_FRAME_BITS = 8 + DATA_W;
    localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_CMD_LAST  = c_CNT_W'(7);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(c_FRAME_BITS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CMD  = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Synchronizers: stages 1-2 resolve metastability, stage 3 is the edge reference.
    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_csn_s1,  r_csn_s2,  r_csn_s3;
    logic r_mosi_s1, r_mosi_s2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [6:0]         r_cmd;      // first seven command bits; the 8th comes straight from mosi
    logic               r_rd;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-2:0]  r_rx;       // received data less its final bit
    logic [DATA_W-1:0]  r_tx;
    logic [DATA_W-1:0]  r_regs [c_NREG];

    logic               r_miso;
    logic               r_miso_oe;
    logic               r_wr_stb;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_frame_done;
    logic               r_frame_err;

    logic               w_sclk_rise;
    logic               w_sclk_fall;
    logic               w_csn_rise;
    logic               w_csn_fall;
    logic [ADDR_W-1:0]  w_cmd_addr;
    logic [DATA_W-1:0]  w_rx_full;

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
    assign w_csn_rise  = r_csn_s2 & ~r_csn_s3;
    assign w_csn_fall  = ~r_csn_s2 & r_csn_s3;

    // Address and data as they stand once the current mosi bit is included.
    assign w_cmd_addr  = {r_cmd[ADDR_W-2:0], r_mosi_s2};
    assign w_rx_full   = {r_rx, r_mosi_s2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_s1    <= 1'b0;
            r_sclk_s2    <= 1'b0;
            r_sclk_s3    <= 1'b0;
            r_csn_s1     <= 1'b1;
            r_csn_s2     <= 1'b1;
            r_csn_s3     <= 1'b1;
            r_mosi_s1    <= 1'b0;
            r_mosi_s2    <= 1'b0;
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_rd         <= 1'b0;
            r_addr       <= '0;
            r_rx         <= '0;
            r_tx         <= '0;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_wr_stb     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_sclk_s1    <= sclk;
            r_sclk_s2    <= r_sclk_s1;
            r_sclk_s3    <= r_sclk_s2;
            r_csn_s1     <= csn;
            r_csn_s2     <= r_csn_s1;
            r_csn_s3     <= r_csn_s2;
            r_mosi_s1    <= mosi;
            r_mosi_s2    <= r_mosi_s1;

            r_miso_oe    <= ~r_csn_s2;
            r_wr_stb     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;

            // Local load first so that an SPI commit below overrides it.
            if (ld_en) begin
                r_regs[ld_addr] <= ld_data;
            end

            if (w_csn_rise) begin
                r_frame_done <= (r_state == c_DONE);
                r_frame_err  <= (r_state == c_CMD) || (r_state == c_DATA);
                r_state      <= c_IDLE;
                r_miso       <= 1'b0;
            end else if (w_csn_fall) begin
                // Every new frame starts from a clean slate.
                r_state <= c_CMD;
                r_cnt   <= '0;
                r_cmd   <= '0;
                r_rd    <= 1'b0;
                r_rx    <= '0;
                r_tx    <= '0;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    c_CMD: begin
                        if (w_sclk_rise) begin
                            r_cmd <= {r_cmd[5:0], r_mosi_s2};
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == c_CMD_LAST) begin
                                r_state <= c_DATA;
                                r_rd    <= r_cmd[6];
                                r_addr  <= w_cmd_addr;
                                if (r_cmd[6]) begin
                                    r_tx <= r_regs[w_cmd_addr];
                                end
                            end
                        end
                    end
                    c_DATA: begin
                        if (w_sclk_rise) begin
                            r_rx  <= w_rx_full[DATA_W-2:0];
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == c_DATA_LAST) begin
                                r_state <= c_DONE;
                                if (!r_rd) begin
                                    r_regs[r_addr] <= w_rx_full;
                                    r_wr_stb       <= 1'b1;
                                    r_wr_addr      <= r_addr;
                                    r_wr_data      <= w_rx_full;
                                end
                            end
                        end
                    end
                    default: ;
                endcase

                // miso moves only on sclk falls; it carries data only while
                // a read frame is in its data phase.
                if (w_sclk_fall) begin
                    if ((r_state == c_DATA) && r_rd) begin
                        r_miso <= r_tx[DATA_W-1];
                        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
            end
        end
    end

    assign miso       = r_miso;
    assign miso_oe    = r_miso_oe;
    assign wr_stb     = r_wr_stb;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_tmc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmc_spi_responder
// Description : Directed vector bench for tmc_spi_responder. A table of SPI
//               frames with hand-computed results, plus hand-written
//               sequences for load/commit collisions, snapshot isolation and
//               reset in the middle of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmc_spi_responder;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          sclk;
    logic          csn;
    logic          mosi;
    logic          miso;
    logic          miso_oe;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_done;
    logic          frame_err;

    tmc_spi_responder #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .csn        (csn),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec;
    int nfail;

    // Cumulative event monitor; the test takes deltas around each frame.
    int            rise_cnt;
    int            wr_cnt;
    int            done_cnt;
    int            err_cnt;
    int            last_wr_pos;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    initial begin
        wr_cnt       = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        last_wr_pos  = 0;
        last_wr_addr = '0;
        last_wr_data = '0;
    end

    always @(negedge clk) begin
        if (wr_stb) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_pos  = rise_cnt;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (frame_done) done_cnt = done_cnt + 1;
        if (frame_err)  err_cnt  = err_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec = nvec + 1;
        if (got !== exp) begin
            nfail = nfail + 1;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One sclk half period = clk/8 overall.
    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    // Full SPI transaction. miso is sampled just before each sclk rise, as the
    // master would. ld_bit >= 0 fires a one-clk ld_en timed to land in the
    // same clk as the DUT's processing of that sclk rise.
    task automatic spi_xfer(input logic [7:0] cmd, input logic [DW-1:0] data,
                            input int nbits, input int ld_bit,
                            input logic [AW-1:0] la, input logic [DW-1:0] ld,
                            output logic [31:0] rx, output logic oe_mid,
                            output logic stb_at_ld);
        logic [23:0] frame;
        frame     = {cmd, data};
        rise_cnt  = 0;
        rx        = '0;
        oe_mid    = 1'b0;
        stb_at_ld = 1'b0;
        csn       = 1'b0;
        half();
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 24) ? frame[23 - i] : 1'b0;
            half();
            rx = {rx[30:0], miso};
            if (i == 4) oe_mid = miso_oe;
            sclk     = 1'b1;
            rise_cnt = rise_cnt + 1;
            if (i == ld_bit) begin
                @(negedge clk);
                @(negedge clk);
                ld_en   = 1'b1;
                ld_addr = la;
                ld_data = ld;
                @(negedge clk);
                ld_en     = 1'b0;
                stb_at_ld = wr_stb;
                @(negedge clk);
            end else begin
                half();
            end
            sclk = 1'b0;
        end
        half();
        csn  = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]    cmd;
        logic [DW-1:0] data;
        int            nbits;
        int            exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        int            exp_done;
        int            exp_err;
        logic [31:0]   exp_rx;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [31:0] rx;
        logic        oe_mid;
        logic        stb;
        int          w0, d0, e0;

        nvec = 0;
        nfail = 0;
        rise_cnt = 0;

        //            cmd    data      bits wr addr  wdata     done err rx
        tbl[0] = '{8'h02, 16'hBEEF, 24, 1, 3'd2, 16'hBEEF, 1, 0, 32'h0000_0000};
        tbl[1] = '{8'h82, 16'h0000, 24, 0, 3'd0, 16'h0000, 1, 0, 32'h0000_BEEF};
        tbl[2] = '{8'h85, 16'h0000, 24, 0, 3'd0, 16'h0000, 1, 0, 32'h0000_1234};
        tbl[3] = '{8'h01, 16'h5A5A, 20, 0, 3'd0, 16'h0000, 0, 1, 32'h0000_0000};
        tbl[4] = '{8'h81, 16'h0000, 24, 0, 3'd0, 16'h0000, 1, 0, 32'h0000_0000};
        tbl[5] = '{8'h07, 16'h1357, 30, 1, 3'd7, 16'h1357, 1, 0, 32'h0000_0000};
        tbl[6] = '{8'h87, 16'h0000, 24, 0, 3'd0, 16'h0000, 1, 0, 32'h0000_1357};
        tbl[7] = '{8'h7C, 16'hC3C3, 24, 1, 3'd4, 16'hC3C3, 1, 0, 32'h0000_0000};
        tbl[8] = '{8'hF4, 16'h0000, 24, 0, 3'd0, 16'h0000, 1, 0, 32'h0000_C3C3};

        rst     = 1'b1;
        sclk    = 1'b0;
        csn     = 1'b1;
        mosi    = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'd0, miso, miso_oe, wr_stb, frame_done, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_miso_oe", {31'd0, miso_oe}, 32'd0);

        // Preload register 5 through the local port.
        ld_en   = 1'b1;
        ld_addr = 3'd5;
        ld_data = 16'h1234;
        @(negedge clk);
        ld_en   = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            w0 = wr_cnt;
            d0 = done_cnt;
            e0 = err_cnt;
            spi_xfer(tbl[v].cmd, tbl[v].data, tbl[v].nbits, -1, '0, '0, rx, oe_mid, stb);
            chk($sformatf("v%0d_wr_count", v),   32'(wr_cnt - w0),   32'(tbl[v].exp_wr));
            chk($sformatf("v%0d_frame_done", v), 32'(done_cnt - d0), 32'(tbl[v].exp_done));
            chk($sformatf("v%0d_frame_err", v),  32'(err_cnt - e0),  32'(tbl[v].exp_err));
            chk($sformatf("v%0d_miso_bits", v),  rx,                 tbl[v].exp_rx);
            chk($sformatf("v%0d_oe_mid", v),     {31'd0, oe_mid},    32'd1);
            if (tbl[v].exp_wr == 1) begin
                chk($sformatf("v%0d_wr_addr", v), {29'd0, last_wr_addr}, {29'd0, tbl[v].exp_addr});
                chk($sformatf("v%0d_wr_data", v), {16'd0, last_wr_data}, {16'd0, tbl[v].exp_wdata});
                chk($sformatf("v%0d_wr_pos", v),  32'(last_wr_pos),      32'd24);
            end
        end
        chk("post_frame_oe", {31'd0, miso_oe}, 32'd0);

        // SPI commit and local load to the same address in the same clk.
        w0 = wr_cnt;
        spi_xfer(8'h03, 16'hAAAA, 24, 23, 3'd3, 16'h5555, rx, oe_mid, stb);
        chk("collide_same_align", {31'd0, stb}, 32'd1);
        chk("collide_same_wr", 32'(wr_cnt - w0), 32'd1);
        spi_xfer(8'h83, 16'h0000, 24, -1, '0, '0, rx, oe_mid, stb);
        chk("collide_same_reg3", rx, 32'h0000_AAAA);

        // Same clk, different addresses: both must land.
        spi_xfer(8'h03, 16'h0F0F, 24, 23, 3'd6, 16'h6666, rx, oe_mid, stb);
        chk("collide_diff_align", {31'd0, stb}, 32'd1);
        spi_xfer(8'h83, 16'h0000, 24, -1, '0, '0, rx, oe_mid, stb);
        chk("collide_diff_reg3", rx, 32'h0000_0F0F);
        spi_xfer(8'h86, 16'h0000, 24, -1, '0, '0, rx, oe_mid, stb);
        chk("collide_diff_reg6", rx, 32'h0000_6666);

        // Load to the register being read, after the snapshot.
        spi_xfer(8'h85, 16'h0000, 24, 12, 3'd5, 16'hFFFF, rx, oe_mid, stb);
        chk("snapshot_isolated", rx, 32'h0000_1234);
        spi_xfer(8'h85, 16'h0000, 24, -1, '0, '0, rx, oe_mid, stb);
        chk("snapshot_ld_landed", rx, 32'h0000_FFFF);

        // Reset at bit 10 of a write frame.
        w0 = wr_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
        begin
            logic [23:0] frame;
            frame = {8'h06, 16'h9999};
            csn = 1'b0;
            half();
            for (int i = 0; i < 10; i++) begin
                mosi = frame[23 - i];
                half();
                sclk = 1'b1;
                half();
                sclk = 1'b0;
            end
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset_outputs", {27'd0, miso, miso_oe, wr_stb, frame_done, frame_err}, 32'd0);
        csn  = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midreset_no_wr",   32'(wr_cnt - w0),   32'd0);
        chk("midreset_no_err",  32'(err_cnt - e0),  32'd0);
        chk("midreset_no_done", 32'(done_cnt - d0), 32'd0);

        w0 = wr_cnt;
        d0 = done_cnt;
        spi_xfer(8'h06, 16'h4321, 24, -1, '0, '0, rx, oe_mid, stb);
        chk("after_reset_wr",   32'(wr_cnt - w0),   32'd1);
        chk("after_reset_done", 32'(done_cnt - d0), 32'd1);
        chk("after_reset_data", {16'd0, last_wr_data}, 32'h0000_4321);
        spi_xfer(8'h86, 16'h0000, 24, -1, '0, '0, rx, oe_mid, stb);
        chk("after_reset_read6", rx, 32'h0000_4321);
        spi_xfer(8'h85, 16'h0000, 24, -1, '0, '0, rx, oe_mid, stb);
        chk("after_reset_reg5_cleared", rx, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmc_spi_responder.md
TMC_SPI_RESPONDER -- requirements
Module: tmc_spi_responder

Interface
REQ-001 Parameter: DATA_W, default 16, width of register data and of the frame data phase.
REQ-002 Parameter: ADDR_W, default 3, register address width, giving 2**ADDR_W registers.
REQ-003 Port: clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: sclk  in  1  SPI clock from the master, asynchronous to clk.
REQ-006 Port: csn  in  1  SPI chip select from the master, active-low, asynchronous.
REQ-007 Port: mosi  in  1  SPI data from the master, asynchronous.
REQ-008 Port: miso  out  1  SPI data to the master.
REQ-009 Port: miso_oe  out  1  miso output enable, high only while the synchronized csn is low.
REQ-010 Port: ld_en  in  1  local register load strobe.
REQ-011 Port: ld_addr  in  ADDR_W  local load address.
REQ-012 Port: ld_data  in  DATA_W  local load data.
REQ-013 Port: wr_stb  out  1  one-clk pulse when an SPI write commits.
REQ-014 Port: wr_addr  out  ADDR_W  address of the last committed SPI write.
REQ-015 Port: wr_data  out  DATA_W  data of the last committed SPI write.
REQ-016 Port: frame_done  out  1  one-clk pulse on csn rise after a complete frame.
REQ-017 Port: frame_err  out  1  one-clk pulse on csn rise after an incomplete frame.

Function
REQ-018 The block SHALL pass sclk, csn and mosi through 2-FF synchronizers, then detect edges on a third registered stage; it SHALL support sclk up to clk/8.
REQ-019 Protocol: SPI mode 0 (CPOL=0, CPHA=0), MSB first; the block SHALL sample mosi on each sclk rising edge and change miso only on sclk falling edges.
REQ-020 Frame format: 8-bit command, then DATA_W data bits; command bit 7 = read (1) / write (0), bits ADDR_W-1:0 = address, all other command bits ignored.
REQ-021 FSM states: IDLE, CMD, DATA, DONE.
REQ-022 FSM, IDLE to CMD: on a csn fall, clear the bit counter.
REQ-023 FSM, CMD to DATA: after the 8th rising edge.
REQ-024 FSM, DATA to DONE: after the (8+DATA_W)th rising edge.
REQ-025 FSM, any state to IDLE: on a csn rise.
REQ-026 On the 8th rising edge, a read command SHALL copy reg[addr] into the transmit shift register.
REQ-027 miso SHALL be 0 during CMD and DONE, and during DATA of a write frame.
REQ-028 For a read frame, miso SHALL present data MSB from the 8th sclk falling edge and shift one bit on each subsequent falling edge.
REQ-029 For a write frame, on the (8+DATA_W)th rising edge the block SHALL write the received data to reg[addr] and pulse wr_stb, with wr_addr and wr_data valid in the same cycle as wr_stb.
REQ-030 In DONE, extra sclk edges SHALL be ignored: no further writes, no counter wrap.
REQ-031 On a csn rise in DONE, the block SHALL pulse frame_done.
REQ-032 On a csn rise in CMD or DATA (abort), the block SHALL pulse frame_err, perform no register write, and discard partial data.
REQ-033 ld_en SHALL write ld_data to reg[ld_addr] one clk later.
REQ-034 If ld_en and an SPI commit target the same address in the same clk, the SPI write SHALL win; to different addresses, both SHALL complete.
REQ-035 A ld_en to the address being read after the read snapshot (REQ-026) SHALL NOT alter bits already being shifted.
REQ-036 A csn fall while csn is still synchronizing high SHALL start a fresh frame, with no carry-over of counter or shift register.

Reset
REQ-037 While rst is high, the FSM SHALL be IDLE and all registers and the bit counter SHALL be 0.
REQ-038 While rst is high, miso, miso_oe, wr_stb, frame_done and frame_err SHALL be 0.
REQ-039 While rst is high, the synchronizer stages SHALL be set to csn=1, sclk=0, mosi=0.
REQ-040 On rst mid-frame, the block SHALL abandon the frame with no write and no frame_err, then wait in IDLE for a new csn fall.

Verification
REQ-041 Write 0x02, 0xBEEF at sclk = clk/8 -> wr_stb once, wr_addr=2, wr_data=0xBEEF; frame_done on csn rise; a later read of addr 2 returns 0xBEEF.
REQ-042 ld_en addr 5, data 0x1234, then read command 0x85 -> miso 0 for 8 bits, then 0001_0010_0011_0100 sampled on rising edges.
REQ-043 Write frame to addr 1 with csn raised after 12 data bits -> frame_err pulse, no wr_stb, reg[1] unchanged.
REQ-044 ld_en and SPI commit both to addr 3 in the same clk, SPI data 0xAAAA, ld 0x5555 -> reg[3]=0xAAAA.
REQ-045 30 sclk cycles in one write frame -> exactly one wr_stb at bit 24, miso 0 afterward, frame_done on csn rise.
REQ-046 rst asserted at bit 10 of a write frame -> all outputs 0, no wr_stb; the next complete frame operates normally.
